// File: rtl/sign_mag_disp_mux.sv
`default_nettype none
// ============================================================================
// Module      : sign_mag_disp_mux
// Description : Captures an N-bit sign-magnitude value on a load strobe and
//               shows it on a 4-digit, time-multiplexed, active-low
//               seven-segment display. The magnitude appears as hex on digits
//               1..0 with the leading zero blanked. Digit 3 shows '-' for a
//               non-zero negative value. Digit 2 is always blank.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_mag_disp_mux #(
    parameter int N            = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sum_in,
    input  logic         load,
    output logic [3:0]   an,
    output logic [7:0]   sseg
);

    // Active-low segment patterns. Bit 7 is dp, which is always off.
    localparam logic [7:0] c_SEG_BLANK = 8'hFF;
    localparam logic [7:0] c_SEG_DASH  = 8'hBF;
    localparam logic [REFRESH_BITS-1:0] c_Q_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [N-1:0]            r_val;
    logic [REFRESH_BITS-1:0] r_q;
    logic [1:0]              w_sel;
    logic [7:0]              w_mag;
    logic                    w_neg;
    logic [3:0]              w_an_next;
    logic [7:0]              w_sseg_next;

    // Hex nibble to active-low seven-segment pattern (g..a in bits 6..0).
    function automatic logic [7:0] hex_to_sseg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Capture register: follows sum_in whenever load is high, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val <= '0;
        end else if (load) begin
            r_val <= sum_in;
        end
    end

    // Free-running refresh counter; natural wrap gives a seamless 3 -> 0 scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + c_Q_ONE;
        end
    end

    assign w_sel = r_q[REFRESH_BITS-1:REFRESH_BITS-2];
    // With N <= 9 the magnitude is at most 8 bits, so it always fits here.
    assign w_mag = 8'(r_val[N-2:0]);
    // Negative zero is shown as plain "0", so the minus needs a non-zero magnitude.
    assign w_neg = r_val[N-1] & (w_mag != 8'd0);

    // Select the active digit's enable and segment pattern.
    always_comb begin
        w_an_next   = 4'b1111;
        w_sseg_next = c_SEG_BLANK;
        case (w_sel)
            2'd0: begin
                w_an_next   = 4'b1110;
                w_sseg_next = hex_to_sseg(w_mag[3:0]);
            end
            2'd1: begin
                w_an_next = 4'b1101;
                if (w_mag[7:4] != 4'h0) begin
                    w_sseg_next = hex_to_sseg(w_mag[7:4]);
                end
            end
            2'd2: begin
                w_an_next = 4'b1011;
            end
            default: begin
                w_an_next = 4'b0111;
                if (w_neg) begin
                    w_sseg_next = c_SEG_DASH;
                end
            end
        endcase
    end

    // Registered display outputs, blanked while in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= 4'b1111;
            sseg <= c_SEG_BLANK;
        end else begin
            an   <= w_an_next;
            sseg <= w_sseg_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sign_mag_disp_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_sign_mag_disp_mux
// Description : Directed self-checking bench for sign_mag_disp_mux with an
//               N=4 and an N=8 instance, both using a 4-bit refresh counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_mag_disp_mux;

    logic       clk;
    logic       reset;
    logic [3:0] sum4;
    logic       load4;
    logic [7:0] sum8;
    logic       load8;
    logic [3:0] an4;
    logic [7:0] sseg4;
    logic [3:0] an8;
    logic [7:0] sseg8;

    int vectors;
    int miscompares;
    int model_q;   // expected refresh counter value after the most recent edge

    sign_mag_disp_mux #(.N(4), .REFRESH_BITS(4)) u_dut4 (
        .clk    (clk),
        .reset  (reset),
        .sum_in (sum4),
        .load   (load4),
        .an     (an4),
        .sseg   (sseg4)
    );

    sign_mag_disp_mux #(.N(8), .REFRESH_BITS(4)) u_dut8 (
        .clk    (clk),
        .reset  (reset),
        .sum_in (sum8),
        .load   (load8),
        .an     (an8),
        .sseg   (sseg8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        model_q = (model_q + 1) % 16;
    endtask

    // Run until the next edge will show digit 0 (at most 15 edges).
    task automatic align();
        while (model_q != 0) step();
    endtask

    task automatic load_dut4(input logic [3:0] v);
        sum4  = v;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
    endtask

    task automatic load_dut8(input logic [7:0] v);
        sum8  = v;
        load8 = 1'b1;
        step();
        load8 = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (an4 !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_an4: got %b want 1111", an4);
        end
        vectors++;
        if (sseg4 !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_sseg4: got %h want FF", sseg4);
        end
        vectors++;
        if (sseg8 !== 8'hFF || an8 !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_dut8: got an=%b sseg=%h want 1111/FF", an8, sseg8);
        end
        #2;
        reset   = 1'b0;
        model_q = 0;
        step();
        vectors++;
        if (an4 !== 4'b1110 || sseg4 !== 8'hC0) begin
            miscompares++;
            $display("FAIL first_edge4: got an=%b sseg=%h want 1110/C0", an4, sseg4);
        end
        vectors++;
        if (an8 !== 4'b1110 || sseg8 !== 8'hC0) begin
            miscompares++;
            $display("FAIL first_edge8: got an=%b sseg=%h want 1110/C0", an8, sseg8);
        end
    endtask

    // Full scan of -2 on N=4, plus the 3 -> 0 wrap.
    task automatic test_scan_neg2();
        logic [7:0] tbl [4];
        logic [3:0] exp_an;
        tbl = '{8'hA4, 8'hFF, 8'hFF, 8'hBF};
        load_dut4(4'b1010);
        align();
        for (int i = 0; i < 16; i++) begin
            step();
            exp_an = ~(4'b0001 << (i / 4));
            vectors++;
            if (an4 !== exp_an || sseg4 !== tbl[i/4]) begin
                miscompares++;
                $display("FAIL scan_neg2[%0d]: got an=%b sseg=%h want %b/%h",
                         i, an4, sseg4, exp_an, tbl[i/4]);
            end
        end
        step();
        vectors++;
        if (an4 !== 4'b1110 || sseg4 !== 8'hA4) begin
            miscompares++;
            $display("FAIL scan_wrap: got an=%b sseg=%h want 1110/A4", an4, sseg4);
        end
    endtask

    // +7 and negative zero on N=4: digit0 and digit3 of a full scan.
    task automatic test_n4_values();
        logic [3:0] vals [2];
        logic [7:0] d0 [2];
        vals = '{4'b0111, 4'b1000};
        d0   = '{8'hF8, 8'hC0};
        for (int p = 0; p < 2; p++) begin
            load_dut4(vals[p]);
            align();
            for (int i = 0; i < 16; i++) begin
                step();
                if (i == 0) begin
                    vectors++;
                    if (an4 !== 4'b1110 || sseg4 !== d0[p]) begin
                        miscompares++;
                        $display("FAIL n4_digit0[%0d]: got an=%b sseg=%h want 1110/%h",
                                 p, an4, sseg4, d0[p]);
                    end
                end else if (i == 12) begin
                    vectors++;
                    if (an4 !== 4'b0111 || sseg4 !== 8'hFF) begin
                        miscompares++;
                        $display("FAIL n4_digit3[%0d]: got an=%b sseg=%h want 0111/FF",
                                 p, an4, sseg4);
                    end
                end
            end
        end
    endtask

    // N=8: -127 and +5 (leading zero blanked).
    task automatic test_n8_values();
        logic [7:0] vals [2];
        logic [7:0] tbl  [2][4];
        logic [3:0] exp_an;
        vals = '{8'hFF, 8'h05};
        tbl  = '{'{8'h8E, 8'hF8, 8'hFF, 8'hBF}, '{8'h92, 8'hFF, 8'hFF, 8'hFF}};
        for (int p = 0; p < 2; p++) begin
            load_dut8(vals[p]);
            align();
            for (int i = 0; i < 16; i++) begin
                step();
                if ((i % 4) == 1) begin
                    exp_an = ~(4'b0001 << (i / 4));
                    vectors++;
                    if (an8 !== exp_an || sseg8 !== tbl[p][i/4]) begin
                        miscompares++;
                        $display("FAIL n8_scan[%0d][%0d]: got an=%b sseg=%h want %b/%h",
                                 p, i, an8, sseg8, exp_an, tbl[p][i/4]);
                    end
                end
            end
        end
    endtask

    // Load while digit0 is active: segments change, an and schedule do not.
    task automatic test_mid_digit_load();
        logic [7:0] exp_seg [5];
        logic [3:0] exp_an  [5];
        exp_seg = '{8'hA4, 8'hA4, 8'hB0, 8'hB0, 8'hFF};
        exp_an  = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101};
        load_dut4(4'b1010);
        align();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                sum4  = 4'b0011;
                load4 = 1'b1;
            end
            step();
            load4 = 1'b0;
            vectors++;
            if (an4 !== exp_an[i] || sseg4 !== exp_seg[i]) begin
                miscompares++;
                $display("FAIL mid_load[%0d]: got an=%b sseg=%h want %b/%h",
                         i, an4, sseg4, exp_an[i], exp_seg[i]);
            end
        end
    endtask

    // load held high: each captured value shows on the following edge.
    task automatic test_back_to_back();
        logic [3:0] vals    [3];
        logic [7:0] exp_seg [4];
        vals    = '{4'b0001, 4'b0010, 4'b0100};
        exp_seg = '{8'hB0, 8'hF9, 8'hA4, 8'h99};
        align();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                sum4  = vals[i];
                load4 = 1'b1;
            end else begin
                load4 = 1'b0;
            end
            step();
            vectors++;
            if (an4 !== 4'b1110 || sseg4 !== exp_seg[i]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got an=%b sseg=%h want 1110/%h",
                         i, an4, sseg4, exp_seg[i]);
            end
        end
    endtask

    // Reset while digit 2 is shown: immediate blank, val lost, scan restarts.
    task automatic test_reset_mid_scan();
        load_dut4(4'b1010);
        load_dut8(8'hFF);
        align();
        for (int i = 0; i < 9; i++) step();
        vectors++;
        if (an4 !== 4'b1011) begin
            miscompares++;
            $display("FAIL pre_reset_digit2: got an=%b want 1011", an4);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (an4 !== 4'b1111 || sseg4 !== 8'hFF) begin
            miscompares++;
            $display("FAIL mid_reset4: got an=%b sseg=%h want 1111/FF", an4, sseg4);
        end
        vectors++;
        if (an8 !== 4'b1111 || sseg8 !== 8'hFF) begin
            miscompares++;
            $display("FAIL mid_reset8: got an=%b sseg=%h want 1111/FF", an8, sseg8);
        end
        #2;
        reset   = 1'b0;
        model_q = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 0) begin
                vectors++;
                if (an4 !== 4'b1110 || sseg4 !== 8'hC0) begin
                    miscompares++;
                    $display("FAIL post_reset_d0_4: got an=%b sseg=%h want 1110/C0", an4, sseg4);
                end
                vectors++;
                if (an8 !== 4'b1110 || sseg8 !== 8'hC0) begin
                    miscompares++;
                    $display("FAIL post_reset_d0_8: got an=%b sseg=%h want 1110/C0", an8, sseg8);
                end
            end else if (i == 12) begin
                vectors++;
                if (an4 !== 4'b0111 || sseg4 !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL post_reset_d3_4: got an=%b sseg=%h want 0111/FF", an4, sseg4);
                end
                vectors++;
                if (an8 !== 4'b0111 || sseg8 !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL post_reset_d3_8: got an=%b sseg=%h want 0111/FF", an8, sseg8);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_q     = 0;
        reset       = 1'b0;
        sum4        = '0;
        load4       = 1'b0;
        sum8        = '0;
        load8       = 1'b0;
        test_reset();
        test_scan_neg2();
        test_n4_values();
        test_n8_values();
        test_mid_digit_load();
        test_back_to_back();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sign_mag_disp_mux.md
# sign_mag_disp_mux

Downstream display stage for the sign-magnitude adder: captures the N-bit sign-magnitude `sum` on a load strobe and shows it on a 4-digit, time-multiplexed, active-low seven-segment display. The magnitude appears as hex on digits 1..0 with the leading zero blanked, digit 3 shows '-' for a non-zero negative value, and digit 2 is always blank. A free-running refresh counter scans the digits; all display outputs are registered.

## Interface
- `N`, default 4: width of the sign-magnitude value. Bit N-1 is the sign; bits N-2..0 are the magnitude. Legal range 2..9, so the magnitude fits in at most 2 hex digits.
- `REFRESH_BITS`, default 18: refresh counter width. The top 2 bits select the digit. Minimum 2; benches use 4.
- `clk` in 1: system clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sum_in` in N: sign-magnitude value from the adder.
- `load` in 1: single-cycle strobe; captures `sum_in` on the rising edge.
- `an` out 4: digit enables, active low. `an[0]` is the rightmost digit.
- `sseg` out 8: segments, active low. Bit 7 is dp; bits 6..0 are g,f,e,d,c,b,a.

## Operation
- Capture register `val` (N bits): on `load`=1, `val` <= `sum_in`; otherwise it holds. Reset value 0.
- Refresh counter `q` (REFRESH_BITS): increments every cycle and wraps from all-ones to 0. Reset value 0. `sel` = `q[REFRESH_BITS-1:REFRESH_BITS-2]`.
- `mag` = `val[N-2:0]`, zero-extended to 8 bits. `neg` = `val[N-1]` & (`mag` != 0). Negative zero (sign=1, mag=0) displays as "0" with no minus.
- Digit content per `sel`:
  - 0: hex of `mag[3:0]`.
  - 1: hex of `mag[7:4]` if `mag[7:4]` != 0, else blank. Blank always when N <= 5.
  - 2: blank.
  - 3: '-' if `neg`, else blank.
- Active-low encodings (`sseg`, dp always off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - '-'=BF, blank=FF
- `an` is one-hot low at index `sel`: 1110, 1101, 1011, 0111.

## Timing
- Reset (asynchronous): `an`=1111, `sseg`=FF, `q`=0, `val`=0, applied immediately and held while `reset`=1.
- First edge after reset release: outputs show `sel`=0, i.e. `an`=1110, `sseg`=C0.
- Output latency: `an`/`sseg` are registered from the current `sel`/`val`, so outputs lag the counter by 1 cycle. Each digit is driven for 2^(REFRESH_BITS-2) consecutive cycles; a full scan takes 2^REFRESH_BITS cycles.
- Load: a value captured at edge k appears on `sseg` from edge k+1 onward, on whichever digit is active. The counter is not disturbed; loading mid-digit changes that digit's segments without changing `an`.
- Back-to-back loads: the last one wins; every captured value is reflected from the following edge.
- `load` held high: `val` tracks `sum_in` every cycle.
- Counter wrap: `sel` goes 3 -> 0 seamlessly, with no blank cycle.
- Reset asserted mid-scan: immediate blanking (`an`=1111); `val` is cleared, so a prior load is lost.

## Test plan
- Reset: assert `reset` asynchronously between edges -> `an`=1111 and `sseg`=FF without waiting for an edge; after release, first edge -> `an`=1110, `sseg`=C0.
- N=4, REFRESH_BITS=4, load 4'b1010 (-2) -> over one 16-cycle scan:
  - `an`=1110 / `sseg`=A4 for 4 cycles
  - then 1101/FF, 1011/FF, 0111/BF
- N=4, load 4'b0111 (+7) -> digit0 F8, digit3 FF. Load 4'b1000 (-0) -> digit0 C0, digit3 FF (no minus).
- N=8, load 8'hFF (-127) -> digit0 8E, digit1 F8, digit3 BF. Load 8'h05 -> digit1 FF (leading zero blanked), digit0 92.
- Mid-digit load: while `an`=1110 showing A4, load 4'b0011 -> next edge `sseg`=B0, `an` still 1110, and the digit still ends on schedule.
- Reset mid-scan with `sel`=2 -> immediate 1111/FF; after release, scan restarts at digit0 with `val`=0, so digit0 shows C0 and digit3 shows FF.
